// File: rtl/heartbeat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : heartbeat_pkg
//  Description : Shared types and default constants for the heartbeat
//                receive path (monitor FSM states, parameter defaults,
//                edge-counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package heartbeat_pkg;

    // Monitor link state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } hb_state_t;

    // Default parameter values for heartbeat_monitor
    localparam int unsigned c_DEF_CNT_W      = 16;
    localparam int unsigned c_DEF_MIN_PERIOD = 4;
    localparam int unsigned c_DEF_TIMEOUT    = 1000;
    localparam int unsigned c_DEF_LOCK_COUNT = 4;

    // Width of the rising-edge counter (wraps 255 -> 0)
    localparam int unsigned c_EDGE_CNT_W     = 8;

endpackage : heartbeat_pkg
`default_nettype wire

// File: rtl/hb_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : hb_sync_edge
//  Description : Two-flop synchroniser for an asynchronous pad input followed
//                by a history flop, giving a clean synchronised level and a
//                one-cycle rising-edge strobe.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                sig_i    - asynchronous input level
//                sig_s_o  - synchronised level (second sync flop)
//                rise_o   - high for one cycle after a 0->1 on sig_s_o
//  Revision    : 1.0 - initial release
// ============================================================================
module hb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sig_s_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sig_s_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule : hb_sync_edge
`default_nettype wire

// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : heartbeat_monitor
//  Description : Receive-side heartbeat checker. Synchronises sig_in, measures
//                the rise-to-rise period, declares the link alive after
//                LOCK_COUNT consecutive legal periods and raises sticky flags
//                for too-fast edges and loss of heartbeat while locked.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                sig_in        - heartbeat from pad (asynchronous)
//                clr_err       - clears err_fast / err_lost (set wins)
//                alive         - high while LOCKED
//                period        - last measured period in clk cycles
//                period_valid  - one-cycle pulse when period updates
//                edge_cnt      - count of detected rises (wrapping)
//                err_fast      - sticky: period < MIN_PERIOD seen
//                err_lost      - sticky: timeout while LOCKED
//  Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_monitor
    import heartbeat_pkg::*;
#(
    parameter int unsigned CNT_W      = c_DEF_CNT_W,
    parameter int unsigned MIN_PERIOD = c_DEF_MIN_PERIOD,
    parameter int unsigned TIMEOUT    = c_DEF_TIMEOUT,
    parameter int unsigned LOCK_COUNT = c_DEF_LOCK_COUNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sig_in,
    input  logic                    clr_err,
    output logic                    alive,
    output logic [CNT_W-1:0]        period,
    output logic                    period_valid,
    output logic [c_EDGE_CNT_W-1:0] edge_cnt,
    output logic                    err_fast,
    output logic                    err_lost
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [GOOD_W-1:0] c_GOOD_SAT  = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W:0]   c_GOOD_LOCK = (GOOD_W + 1)'(LOCK_COUNT);

    // ------------------------------------------------------------------
    // Front end
    // ------------------------------------------------------------------
    logic rise;
    logic sync_level_unused;

    hb_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (sig_in),
        .sig_s_o (sync_level_unused),
        .rise_o  (rise)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hb_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [GOOD_W-1:0]         good_q, good_d;
    logic [CNT_W-1:0]          period_q, period_d;
    logic                      pv_q, pv_d;
    logic [c_EDGE_CNT_W-1:0]   edge_q, edge_d;
    logic                      err_fast_q, err_fast_d;
    logic                      err_lost_q, err_lost_d;
    logic                      alive_q, alive_d;

    logic [CNT_W-1:0]          cnt_plus1;
    logic [GOOD_W:0]           good_inc;
    logic                      timeout;
    logic                      is_fast;
    logic                      set_fast;
    logic                      set_lost;

    // Period of the current rise; cnt never exceeds TIMEOUT-1 so this
    // cannot overflow CNT_W bits.
    assign cnt_plus1 = cnt_q + CNT_W'(1);
    assign is_fast   = (cnt_plus1 < c_MIN_P);
    // One bit wider so good+1 == LOCK_COUNT compares without truncation.
    assign good_inc  = {1'b0, good_q} + (GOOD_W + 1)'(1);
    // A rise in the same cycle takes priority over the timeout.
    assign timeout   = (cnt_q == c_CNT_LAST) & ~rise & (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        period_d = period_q;
        pv_d     = 1'b0;
        set_fast = 1'b0;
        set_lost = 1'b0;
        edge_d   = rise ? (edge_q + c_EDGE_CNT_W'(1)) : edge_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    // First edge only establishes the reference point.
                    state_d = TRACK;
                    good_d  = '0;
                end
            end

            TRACK: begin
                if (rise) begin
                    cnt_d    = '0;
                    period_d = cnt_plus1;
                    pv_d     = 1'b1;
                    if (is_fast) begin
                        set_fast = 1'b1;
                        good_d   = '0;
                    end else begin
                        if (good_q != c_GOOD_SAT) begin
                            good_d = good_inc[GOOD_W-1:0];
                        end
                        if (good_inc == c_GOOD_LOCK) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (timeout) begin
                    // Never locked, so losing it is not an error.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_plus1;
                end
            end

            LOCKED: begin
                if (rise) begin
                    cnt_d    = '0;
                    period_d = cnt_plus1;
                    pv_d     = 1'b1;
                    if (is_fast) begin
                        set_fast = 1'b1;
                        good_d   = '0;
                        state_d  = TRACK;
                    end
                end else if (timeout) begin
                    set_lost = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_plus1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                good_d  = '0;
            end
        endcase

        // Sticky flags: a set in the same cycle beats the clear.
        err_fast_d = set_fast | (err_fast_q & ~clr_err);
        err_lost_d = set_lost | (err_lost_q & ~clr_err);
        alive_d    = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            good_q     <= '0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            edge_q     <= '0;
            err_fast_q <= 1'b0;
            err_lost_q <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_q     <= good_d;
            period_q   <= period_d;
            pv_q       <= pv_d;
            edge_q     <= edge_d;
            err_fast_q <= err_fast_d;
            err_lost_q <= err_lost_d;
            alive_q    <= alive_d;
        end
    end

    assign alive        = alive_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign edge_cnt     = edge_q;
    assign err_fast     = err_fast_q;
    assign err_lost     = err_lost_q;

endmodule : heartbeat_monitor
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heartbeat_monitor
//  Description : Self-checking bench for heartbeat_monitor. An event-time
//                reference model (rise timestamps, gaps, run of legal periods)
//                is compared against the DUT on every cycle, plus literal
//                expectations at the directed checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_heartbeat_monitor;

    localparam int CNT_W = 16;
    localparam int MIN_P = 4;
    localparam int TMO   = 1000;
    localparam int LOCK  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             clr_err = 1'b0;
    logic             alive;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [7:0]       edge_cnt;
    logic             err_fast;
    logic             err_lost;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    heartbeat_monitor #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_P),
        .TIMEOUT    (TMO),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .clr_err      (clr_err),
        .alive        (alive),
        .period       (period),
        .period_valid (period_valid),
        .edge_cnt     (edge_cnt),
        .err_fast     (err_fast),
        .err_lost     (err_lost)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on edge timestamps. A sample of 1 following a
    // sample of 0 produces a rise whose effect lands two edges later.
    // ------------------------------------------------------------------
    int       k = 0;
    bit       started = 0;
    bit       prev_samp = 0;
    int       due[$];
    bit       have_ref = 0;
    bit       m_locked = 0;
    int       good_run = 0;
    int       last_rise = 0;
    int       m_period = 0;
    bit       m_pv = 0;
    logic [7:0] m_ecnt = 8'd0;
    bit       m_ef = 0;
    bit       m_el = 0;

    always @(posedge clk) begin
        bit is_rise;
        bit set_f;
        bit set_l;
        int p;
        k++;
        if (rst) begin
            started   = 1;
            prev_samp = 0;
            due.delete();
            have_ref  = 0;
            m_locked  = 0;
            good_run  = 0;
            m_period  = 0;
            m_pv      = 0;
            m_ecnt    = 8'd0;
            m_ef      = 0;
            m_el      = 0;
        end else begin
            is_rise = 0;
            set_f   = 0;
            set_l   = 0;
            m_pv    = 0;
            if (due.size() > 0 && due[0] == k) begin
                is_rise = 1;
                void'(due.pop_front());
            end
            if (sig_in && !prev_samp) due.push_back(k + 2);
            prev_samp = sig_in;

            if (is_rise) begin
                m_ecnt = m_ecnt + 8'd1;
                if (!have_ref) begin
                    have_ref  = 1;
                    good_run  = 0;
                    last_rise = k;
                end else begin
                    p         = k - last_rise;
                    last_rise = k;
                    m_pv      = 1;
                    m_period  = p;
                    if (p < MIN_P) begin
                        set_f    = 1;
                        good_run = 0;
                        m_locked = 0;
                    end else if (!m_locked) begin
                        good_run++;
                        if (good_run >= LOCK) m_locked = 1;
                    end
                end
            end else if (have_ref && (k - last_rise) == TMO) begin
                if (m_locked) set_l = 1;
                m_locked = 0;
                have_ref = 0;
            end

            m_ef = set_f ? 1'b1 : (clr_err ? 1'b0 : m_ef);
            m_el = set_l ? 1'b1 : (clr_err ? 1'b0 : m_el);
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("alive",        {31'd0, alive},        {31'd0, m_locked});
            chk("period",       {16'd0, period},       32'(m_period));
            chk("period_valid", {31'd0, period_valid}, {31'd0, m_pv});
            chk("edge_cnt",     {24'd0, edge_cnt},     {24'd0, m_ecnt});
            chk("err_fast",     {31'd0, err_fast},     {31'd0, m_ef});
            chk("err_lost",     {31'd0, err_lost},     {31'd0, m_el});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive on the falling edge)
    // ------------------------------------------------------------------
    task automatic pulse(input int spacing, input int high, input int clr_at);
        for (int i = 0; i < spacing; i++) begin
            @(negedge clk);
            sig_in  = (i < high);
            clr_err = (i == clr_at);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig_in  = 1'b0;
            clr_err = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sig_in = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alive"},    {31'd0, alive},        32'd0);
        chk({tag, ".period"},   {16'd0, period},       32'd0);
        chk({tag, ".pv"},       {31'd0, period_valid}, 32'd0);
        chk({tag, ".edge_cnt"}, {24'd0, edge_cnt},     32'd0);
        chk({tag, ".err_fast"}, {31'd0, err_fast},     32'd0);
        chk({tag, ".err_lost"}, {31'd0, err_lost},     32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sp;
        int hi;
        int ca;

        // Reset and quiet line
        do_reset();
        chk_all_zero("reset");
        idle(2000);
        chk_all_zero("quiet");

        // Square wave, period 10: lock after the 5th rise
        for (int i = 0; i < 5; i++) pulse(10, 5, -1);
        chk("sq.alive",    {31'd0, alive},     32'd1);
        chk("sq.period",   {16'd0, period},    32'd10);
        chk("sq.edge_cnt", {24'd0, edge_cnt},  32'd5);

        // Loss of heartbeat while locked, then clear
        idle(1100);
        chk("lost.err_lost", {31'd0, err_lost}, 32'd1);
        chk("lost.alive",    {31'd0, alive},    32'd0);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("lost.clr", {31'd0, err_lost}, 32'd0);

        // Relock, then a fast rise 3 cycles after the previous one
        for (int i = 0; i < 5; i++) pulse(10, 5, -1);
        chk("relock.alive", {31'd0, alive}, 32'd1);
        pulse(3, 1, -1);
        pulse(10, 5, -1);
        chk("fast.period",   {16'd0, period},   32'd3);
        chk("fast.err_fast", {31'd0, err_fast}, 32'd1);
        chk("fast.alive",    {31'd0, alive},    32'd0);
        for (int i = 0; i < 4; i++) pulse(10, 5, -1);
        chk("fast.relock", {31'd0, alive}, 32'd1);

        // clr_err coinciding with a fast detection: set wins
        pulse(3, 1, -1);
        pulse(10, 5, 2);
        chk("setwins.err_fast", {31'd0, err_fast}, 32'd1);
        @(negedge clk); sig_in = 1'b0; clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("clr.err_fast", {31'd0, err_fast}, 32'd0);

        // Reset while locked
        for (int i = 0; i < 4; i++) pulse(10, 5, -1);
        chk("prerst.alive", {31'd0, alive}, 32'd1);
        do_reset();
        chk_all_zero("midrst");

        // 256 rises: edge counter wraps, lock unaffected
        for (int i = 0; i < 256; i++) pulse(10, 5, -1);
        chk("wrap.edge_cnt", {24'd0, edge_cnt}, 32'd0);
        chk("wrap.period",   {16'd0, period},   32'd10);
        chk("wrap.alive",    {31'd0, alive},    32'd1);

        // Randomised spacing, glitches, clears, near-timeout gaps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) sp = $urandom_range(TMO - 10, TMO + 10);
            else                           sp = $urandom_range(2, 14);
            hi = $urandom_range(1, sp - 1);
            ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, sp - 1) : -1;
            if ($urandom_range(0, 199) == 0) do_reset();
            pulse(sp, hi, ca);
        end

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_heartbeat_monitor
`default_nettype wire
